// File: rtl/packet_assembler.sv
// packet_assembler: serialises one 32-clock HDMI data island packet.
// The 24-bit header and each of the four 56-bit subpackets get an 8-bit BCH parity byte
// (generator 1 + x^6 + x^7 + x^8). All of them go out LSB first on a 9-lane symbol bus.
// Lane 0 carries the header. Lanes [4:1] carry even subpacket bits and lanes [8:5] carry odd ones.
module packet_assembler (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             data_island_period,
  input  logic [23:0]      header,
  input  logic [3:0][55:0] sub,
  output logic             packet_enable,
  output logic [4:0]       counter,
  output logic [8:0]       packet_data,
  output logic             packet_data_valid
);

  localparam logic [4:0] LAST_COUNT    = 5'd31;
  localparam logic [4:0] HDR_ECC_START = 5'd24;  // header data occupies counts 0..23
  localparam logic [4:0] SUB_ECC_START = 5'd28;  // subpacket data occupies counts 0..27
  localparam logic [7:0] BCH_POLY      = 8'h83;

  // One serial step of the BCH parity LFSR, fed LSB first.
  function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic din);
    logic fb;
    fb = din ^ ecc[0];
    return {1'b0, ecc[7:1]} ^ (fb ? BCH_POLY : 8'h00);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [4:0]       counter_q, counter_d;
  logic [23:0]      header_q, header_d;
  logic [3:0][55:0] sub_q, sub_d;
  logic [7:0]       hdr_ecc_q, hdr_ecc_d;
  logic [3:0][7:0]  sub_ecc_q, sub_ecc_d;
  logic [8:0]       packet_data_q, packet_data_d;
  logic             packet_data_valid_q, packet_data_valid_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             first_symbol;   // counter sits on the first slot of a packet
  logic [23:0]      cur_header;     // header feeding the current symbol
  logic [3:0][55:0] cur_sub;        // subpackets feeding the current symbol
  logic             hdr_sym;
  logic [7:0]       hdr_ecc_base;
  logic [3:0][7:0]  sub_ecc_base;
  logic [3:0]       sub_even;
  logic [3:0]       sub_odd;

  assign first_symbol = (counter_q == 5'd0);

  // At count 0 the shadows still hold the previous packet, so the live inputs feed that symbol.
  assign cur_header = first_symbol ? header : header_q;
  assign cur_sub    = first_symbol ? sub    : sub_q;

  // The upstream generator advances on the last slot, so its new packet is presented at the next count 0.
  assign packet_enable = data_island_period && (counter_q == LAST_COUNT);

  assign counter           = counter_q;
  assign packet_data       = packet_data_q;
  assign packet_data_valid = packet_data_valid_q;

  // Slot counter and input capture. Leaving the island forces the counter back to 0.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    counter_d = 5'd0;
    header_d  = header_q;
    sub_d     = sub_q;
    if (data_island_period) begin
      counter_d = counter_q + 5'd1;  // 31 wraps naturally to 0
      if (first_symbol) begin
        header_d = header;
        sub_d    = sub;
      end
    end
  end

  // Header lane: data bits for counts 0..23, then the parity byte for counts 24..31.
  always_comb begin
    hdr_ecc_base = first_symbol ? 8'h00 : hdr_ecc_q;
    hdr_ecc_d    = hdr_ecc_q;
    hdr_sym      = 1'b0;
    if (counter_q < HDR_ECC_START) begin
      hdr_sym   = cur_header[counter_q];
      hdr_ecc_d = ecc_step(hdr_ecc_base, hdr_sym);
    end else begin
      // Counts 24..31 have low three bits equal to (count - 24).
      hdr_sym = hdr_ecc_q[counter_q[2:0]];
    end
    if (!data_island_period) begin
      hdr_ecc_d = 8'h00;
    end
  end

  // Subpacket lanes: two data bits per clock for counts 0..27, then two parity bits per clock.
  always_comb begin
    sub_ecc_base = sub_ecc_q;
    sub_ecc_d    = sub_ecc_q;
    sub_even     = 4'd0;
    sub_odd      = 4'd0;
    for (int k = 0; k < 4; k++) begin
      sub_ecc_base[k] = first_symbol ? 8'h00 : sub_ecc_q[k];
      if (counter_q < SUB_ECC_START) begin
        sub_even[k]  = cur_sub[k][{counter_q, 1'b0}];
        sub_odd[k]   = cur_sub[k][{counter_q, 1'b1}];
        // The even bit precedes the odd bit in the serial order, so the LFSR steps twice.
        sub_ecc_d[k] = ecc_step(ecc_step(sub_ecc_base[k], sub_even[k]), sub_odd[k]);
      end else begin
        // Counts 28..31 have low two bits equal to (count - 28).
        sub_even[k] = sub_ecc_q[k][{counter_q[1:0], 1'b0}];
        sub_odd[k]  = sub_ecc_q[k][{counter_q[1:0], 1'b1}];
      end
      if (!data_island_period) begin
        sub_ecc_d[k] = 8'h00;
      end
    end
  end

  // Output symbol: idle symbols are all zero and valid tracks the island one clock late.
  always_comb begin
    packet_data_d       = 9'd0;
    packet_data_valid_d = data_island_period;
    if (data_island_period) begin
      packet_data_d = {sub_odd, sub_even, hdr_sym};
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      counter_q           <= 5'd0;
      // NOTE: the shadows are wide but cheap to clear. Resetting them keeps post-reset behaviour deterministic.
      header_q            <= 24'd0;
      sub_q               <= '0;
      hdr_ecc_q           <= 8'h00;
      sub_ecc_q           <= '0;
      packet_data_q       <= 9'd0;
      packet_data_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      counter_q           <= counter_d;
      header_q            <= header_d;
      sub_q               <= sub_d;
      hdr_ecc_q           <= hdr_ecc_d;
      sub_ecc_q           <= sub_ecc_d;
      packet_data_q       <= packet_data_d;
      packet_data_valid_q <= packet_data_valid_d;
    end
  end

endmodule

// File: doc/packet_assembler.md
Name: packet_assembler

Overview:
- Serialises one 32-clock HDMI data island packet from a parallel packet (24-bit header, four 56-bit subpackets).
- Appends BCH ECC parity to the header and to each subpacket.
- Sits directly downstream of the packet generators (ACR, audio sample, audio InfoFrame) via the packet picker, and feeds TERC4 encoding.
- Emits packet_enable so the upstream generator can advance to its next packet.

Parameters:
- none. Packet length is fixed at 32 clocks, 24 header bits + 8 ECC bits, 56 subpacket bits + 8 ECC bits.

Ports:
- clk_pixel  input  1  pixel clock; all logic on its rising edge
- reset  input  1  asynchronous, active-high reset
- data_island_period  input  1  high while the data island packet region is active
- header  input  24  packet header HB2..HB0, bit 0 transmitted first
- sub  input  4x56  subpackets sub[3:0], bit 0 transmitted first
- packet_enable  output  1  combinational; high when data_island_period && counter==31
- counter  output  5  position within the current packet (0..31)
- packet_data  output  9  registered serial symbol: [0] header stream, [4:1] even subpacket bits, [8:5] odd subpacket bits
- packet_data_valid  output  1  registered; high when packet_data carries a live symbol

Behaviour:
- Reset (asynchronous) clears: counter, header/sub shadow registers, all five ECC registers, packet_data, packet_data_valid. All outputs read 0.
- Counter:
  - When data_island_period=1: increments every clock, wrapping 31->0.
  - When data_island_period=0: forced to 0 on the next edge.
- Capture: on an edge with data_island_period=1 and counter==0, header and sub are latched into shadows.
  - Serialisation at counter 0 uses the live inputs; counters 1..31 use the shadows.
  - Input changes after capture do not affect the packet in flight.
- Upstream handshake: packet_enable fires at counter==31, so upstream registers advance on that same edge and are captured at the following counter==0.
- Header stream (packet_data[0], registered, one-clock latency):
  - counter c<24: header bit c.
  - counter 24..31: header ECC bit (c-24), LSB first.
- Subpacket k stream, for counter c:
  - c<28: packet_data[1+k] = sub[k][2c], packet_data[5+k] = sub[k][2c+1].
  - c=28..31: ECC bits 2(c-28) and 2(c-28)+1 on the same lanes.
- ECC:
  - Per-bit update: fb = bit ^ ecc[0]; ecc_next = {1'b0, ecc[7:1]} ^ (fb ? 8'h83 : 8'h00). Generator polynomial is 1+x^6+x^7+x^8.
  - Subpackets apply the update twice per clock: even bit first, then odd.
  - Cleared at the start of each packet; at counter 0 the bit-0 update is applied against the cleared value.
  - Held once all data bits are consumed (header after c=23, subpackets after c=27).
- packet_data_valid <= data_island_period each clock.
- Idle: when data_island_period=0, packet_data <= 0 on the next edge.
- Abort: if data_island_period drops mid-packet:
  - the partial packet is discarded;
  - counter and ECC return to 0;
  - packet_enable is not issued;
  - the next rise starts a fresh capture at counter 0.
- Back-to-back packets: counter 31->0 with data_island_period held high; ECC for the new packet starts clean with no bubble.
- Reset asserted mid-packet behaves exactly like power-on reset.

Test Plan:
- Reset held 5 clocks, then released with data_island_period=0 -> all outputs 0; counter stays 0.
- All-zero header/sub, one full 32-clock island -> packet_data=0 for all 32 symbols; packet_data_valid high for 32 clocks, lagging data_island_period by 1; packet_enable high only at counter 31.
- header=24'h000001, sub all zero -> packet_data[0] is 1 then 23 zeros, then ECC 8'h4A LSB first (0,1,0,1,0,0,1,0); subpacket lanes all 0.
- Random header/sub, 200 packets back to back -> every symbol matches a golden serial model, including subpacket ECC on lanes [4:1] and [8:5].
- Inputs changed at counters 5 and 20 -> emitted packet reflects only the values present at counter 0.
- data_island_period dropped at counter 17, raised 3 clocks later -> no packet_enable; counter restarts at 0; new packet's ECC is correct. Repeat with reset asserted at counter 9 -> immediate all-zero outputs.
